// File: rtl/pmod_pkg.sv
// Shared constants for the PMOD I/O paths.
// Also provides the helper that sizes the debounce counter.
package pmod_pkg;

  localparam int PMOD_WIDTH       = 8;
  localparam int CLK_HZ           = 100_000_000;
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 1000;

  // The counter must be able to hold DEBOUNCE_CYCLES-1.
  // Sizing it for DEBOUNCE_CYCLES+1 values keeps the width at least 1 bit.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/pmod_debounce_bit.sv
// One PMOD input bit: pad buffer, synchroniser chain, hold-time debounce counter,
// and registered rise/fall pulses aligned with the level change.
module pmod_debounce_bit
  import pmod_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic                   pad_buf;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt;

  // Pad input buffer; the tools place the IBUF on the top-level port.
  assign pad_buf = pad;
  assign s       = sync[SYNC_STAGES-1];

  // A new value is accepted only after it has differed from the current level
  // for DEBOUNCE_CYCLES consecutive cycles; any return to the level restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= {SYNC_STAGES{RESET_VALUE}};
      cnt   <= '0;
      level <= RESET_VALUE;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pad_buf};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmod_in_debounce.sv
// Debounced PMOD input block: per-bit debouncers plus an acknowledged change-event
// mask with a sticky overrun flag for bits that change again before being acknowledged.
module pmod_in_debounce
  import pmod_pkg::*;
#(
  parameter int               WIDTH           = PMOD_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pmod_pad,
  output logic [WIDTH-1:0] pmod_in,
  output logic [WIDTH-1:0] pmod_rise,
  output logic [WIDTH-1:0] pmod_fall,
  output logic             event_valid,
  output logic [WIDTH-1:0] event_mask,
  input  logic             event_ready,
  output logic             event_overrun
);

  logic [WIDTH-1:0] chg;
  logic             ack;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pmod_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VALUE    (RESET_VALUE[i])
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .pad  (pmod_pad[i]),
      .level(pmod_in[i]),
      .rise (pmod_rise[i]),
      .fall (pmod_fall[i])
    );
  end

  assign chg         = pmod_rise | pmod_fall;
  assign event_valid = |event_mask;
  assign ack         = event_valid & event_ready;

  // Changes arriving in the acknowledge cycle are kept for the next round,
  // and such a coincident change does not count as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      event_mask    <= '0;
      event_overrun <= 1'b0;
    end else begin
      event_mask    <= (ack ? '0 : event_mask) | chg;
      event_overrun <= ack ? 1'b0 : (event_overrun | (|(event_mask & chg)));
    end
  end

endmodule

// File: tb/tb_pmod_in_debounce.sv
// Self-checking bench for pmod_in_debounce: directed pad sequences, a window-based
// reference model compared every cycle, and hand-computed spot checks.
module tb_pmod_in_debounce;

  localparam int         SYNC    = 2;
  localparam int         DEB     = 4;
  localparam logic [7:0] RST_VAL = 8'h00;
  localparam int         MAXE    = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pmod_pad;
  logic [7:0] pmod_in, pmod_rise, pmod_fall, event_mask;
  logic       event_valid, event_ready, event_overrun;

  int total = 0;
  int bad   = 0;

  pmod_in_debounce #(
    .WIDTH          (8),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .RESET_VALUE    (RST_VAL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pmod_pad     (pmod_pad),
    .pmod_in      (pmod_in),
    .pmod_rise    (pmod_rise),
    .pmod_fall    (pmod_fall),
    .event_valid  (event_valid),
    .event_mask   (event_mask),
    .event_ready  (event_ready),
    .event_overrun(event_overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after a falling edge, then let n rising edges pass.
  task automatic applyStimulus(input logic [7:0] pad, input logic r, input logic rdy, input int n);
    pmod_pad    = pad;
    rst         = r;
    event_ready = rdy;
    repeat (n) @(negedge clk);
  endtask

  // Reference model: s is the pad value SYNC edges ago (reset value if any reset
  // intervened); a bit flips when the last DEB values of s all differ from its level.
  logic [7:0] padAt [MAXE];
  logic       rstAt [MAXE];
  logic [7:0] sAt   [MAXE];
  int         edgeN = 0;
  logic [7:0] mLevel = RST_VAL, mRise = '0, mFall = '0, mMask = '0;
  logic       mOver = 1'b0;

  always @(posedge clk) begin
    logic [7:0] chg, sNow;
    logic       ack, ok, acc;
    padAt[edgeN] = pmod_pad;
    rstAt[edgeN] = rst;
    sNow = RST_VAL;
    if (edgeN >= SYNC) begin
      ok = 1'b1;
      for (int k = 1; k <= SYNC; k++) if (rstAt[edgeN-k]) ok = 1'b0;
      if (ok) sNow = padAt[edgeN-SYNC];
    end
    sAt[edgeN] = sNow;
    if (rst) begin
      mLevel = RST_VAL;
      mRise  = '0;
      mFall  = '0;
      mMask  = '0;
      mOver  = 1'b0;
    end else begin
      ack   = (mMask != 8'h00) && event_ready;
      chg   = mRise | mFall;
      mOver = ack ? 1'b0 : (mOver || ((mMask & chg) != 8'h00));
      mMask = (ack ? 8'h00 : mMask) | chg;
      mRise = '0;
      mFall = '0;
      for (int b = 0; b < 8; b++) begin
        acc = (edgeN >= DEB - 1);
        for (int k = 0; k < DEB; k++)
          if (acc) if (rstAt[edgeN-k] || (sAt[edgeN-k][b] == mLevel[b])) acc = 1'b0;
        if (acc) begin
          if (sNow[b]) mRise[b] = 1'b1;
          else         mFall[b] = 1'b1;
          mLevel[b] = sNow[b];
        end
      end
    end
    edgeN++;
    #1;
    checkOutput("model_pmod_in", pmod_in, mLevel);
    checkOutput("model_rise", pmod_rise, mRise);
    checkOutput("model_fall", pmod_fall, mFall);
    checkOutput("model_mask", event_mask, mMask);
    checkOutput("model_valid", event_valid, mMask != 8'h00);
    checkOutput("model_overrun", event_overrun, mOver);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset with pads high, then all bits rise 6 cycles after release.
    applyStimulus(8'hFF, 1'b1, 1'b0, 1);
    checkOutput("rst_pmod_in", pmod_in, 8'h00);
    checkOutput("rst_valid", event_valid, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 2);
    checkOutput("rst_mask", event_mask, 8'h00);
    checkOutput("rst_rise", pmod_rise, 8'h00);
    applyStimulus(8'hFF, 1'b0, 1'b0, 5);
    checkOutput("t1_before", pmod_in, 8'h00);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1);
    checkOutput("t1_level", pmod_in, 8'hFF);
    checkOutput("t1_rise", pmod_rise, 8'hFF);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1);
    checkOutput("t1_rise_gone", pmod_rise, 8'h00);
    checkOutput("t1_mask", event_mask, 8'hFF);
    checkOutput("t1_valid", event_valid, 1'b1);
    applyStimulus(8'hFF, 1'b0, 1'b1, 1);
    checkOutput("t1_ack", event_mask, 8'h00);
    applyStimulus(8'h00, 1'b0, 1'b0, 8);
    checkOutput("t1_fall_level", pmod_in, 8'h00);
    checkOutput("t1_fall_mask", event_mask, 8'hFF);
    applyStimulus(8'h00, 1'b0, 1'b1, 1);

    // Two-cycle glitch on pad[0] must be rejected.
    applyStimulus(8'h01, 1'b0, 1'b0, 2);
    applyStimulus(8'h00, 1'b0, 1'b0, 10);
    checkOutput("t2_level", pmod_in, 8'h00);
    checkOutput("t2_valid", event_valid, 1'b0);

    // Single-bit rise and acknowledge.
    applyStimulus(8'h08, 1'b0, 1'b0, 5);
    checkOutput("t3_before", pmod_in, 8'h00);
    applyStimulus(8'h08, 1'b0, 1'b0, 1);
    checkOutput("t3_level", pmod_in, 8'h08);
    checkOutput("t3_rise", pmod_rise, 8'h08);
    applyStimulus(8'h08, 1'b0, 1'b1, 1);
    checkOutput("t3_mask", event_mask, 8'h08);
    applyStimulus(8'h08, 1'b0, 1'b1, 1);
    checkOutput("t3_ack_mask", event_mask, 8'h00);
    checkOutput("t3_ack_valid", event_valid, 1'b0);

    // Rise then fall on pad[1] without acknowledge sets overrun.
    applyStimulus(8'h0A, 1'b0, 1'b0, 8);
    applyStimulus(8'h08, 1'b0, 1'b0, 8);
    checkOutput("t4_mask", event_mask, 8'h02);
    checkOutput("t4_overrun", event_overrun, 1'b1);
    applyStimulus(8'h08, 1'b0, 1'b1, 1);
    checkOutput("t4_ack_mask", event_mask, 8'h00);
    checkOutput("t4_ack_overrun", event_overrun, 1'b0);

    // Fall on bit 2 coincides with the acknowledge of mask 8'h01.
    applyStimulus(8'h0C, 1'b0, 1'b0, 8);
    applyStimulus(8'h0C, 1'b0, 1'b1, 1);
    applyStimulus(8'h0D, 1'b0, 1'b0, 3);
    applyStimulus(8'h09, 1'b0, 1'b0, 6);
    checkOutput("t5_fall", pmod_fall, 8'h04);
    checkOutput("t5_mask_pre", event_mask, 8'h01);
    applyStimulus(8'h09, 1'b0, 1'b1, 1);
    checkOutput("t5_mask", event_mask, 8'h04);
    checkOutput("t5_overrun", event_overrun, 1'b0);
    applyStimulus(8'h09, 1'b0, 1'b1, 1);

    // Reset in the middle of a pad[5] debounce restarts everything.
    applyStimulus(8'h29, 1'b0, 1'b0, 4);
    checkOutput("t6_mid", pmod_in, 8'h09);
    applyStimulus(8'h29, 1'b1, 1'b0, 2);
    checkOutput("t6_rst_level", pmod_in, 8'h00);
    checkOutput("t6_rst_mask", event_mask, 8'h00);
    applyStimulus(8'h29, 1'b0, 1'b0, 5);
    checkOutput("t6_before", pmod_in, 8'h00);
    applyStimulus(8'h29, 1'b0, 1'b0, 1);
    checkOutput("t6_level", pmod_in, 8'h29);
    checkOutput("t6_rise", pmod_rise, 8'h29);
    applyStimulus(8'h29, 1'b0, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
